// File: rtl/mmio_cmd_master.sv
// Byte-serial command master for the 12-bit MMIO space: parses 'W'/'R' commands,
// runs one read or write strobe, and returns one response byte per command.
module mmio_cmd_master #(
    parameter int STROBE_CYCLES = 1,
    parameter int READ_WAIT     = 2,
    parameter int TIMEOUT       = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        re,
    output logic        we,
    output logic [11:0] addr,
    output logic [7:0]  data_write,
    input  logic [7:0]  data_read,
    output logic        busy,
    output logic        overrun,
    output logic [2:0]  dbg_state_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [3:0] STB_LAST  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_BAD  = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AHI   = 3'd1,
        S_ALO   = 3'd2,
        S_DATA  = 3'd3,
        S_WSTB  = 3'd4,
        S_RSTB  = 3'd5,
        S_RWAIT = 3'd6,
        S_RESP  = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic             op_wr_q, op_wr_d;
    logic [3:0]       ah_q, ah_d;
    logic [7:0]       al_q, al_d;
    logic [11:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             re_q, re_d;
    logic             we_q, we_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             overrun_q, overrun_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic collecting;
    logic draining;

    assign collecting = (state_q == S_AHI) || (state_q == S_ALO) || (state_q == S_DATA);
    assign draining   = (state_q == S_WSTB) || (state_q == S_RSTB) ||
                        (state_q == S_RWAIT) || (state_q == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_wr_q    <= 1'b0;
            ah_q       <= '0;
            al_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            overrun_q  <= 1'b0;
            cnt_q      <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_wr_q    <= op_wr_d;
            ah_q       <= ah_d;
            al_q       <= al_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            re_q       <= re_d;
            we_q       <= we_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        ah_d       = ah_q;
        al_d       = al_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        re_d       = re_q;
        we_d       = we_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        overrun_d  = overrun_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;

        // rx has no backpressure: bytes landing while a command executes are lost.
        if (draining && rx_valid) begin
            overrun_d = 1'b1;
        end

        // A byte arriving in the expiry cycle wins over the timeout.
        if (collecting) begin
            if (rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (rx_valid) begin
                    if (rx_data == OP_WRITE) begin
                        op_wr_d = 1'b1;
                        state_d = S_AHI;
                    end else if (rx_data == OP_READ) begin
                        op_wr_d = 1'b0;
                        state_d = S_AHI;
                    end else begin
                        tx_data_d  = RSP_BAD;
                        tx_valid_d = 1'b1;
                        state_d    = S_RESP;
                    end
                end
            end
            S_AHI: begin
                if (rx_valid) begin
                    ah_d    = rx_data[3:0];
                    state_d = S_ALO;
                end
            end
            S_ALO: begin
                if (rx_valid) begin
                    al_d = rx_data;
                    if (op_wr_q) begin
                        state_d = S_DATA;
                    end else begin
                        addr_d  = {ah_q, rx_data};
                        re_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_RSTB;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    wdata_d = rx_data;
                    addr_d  = {ah_q, al_q};
                    we_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WSTB;
                end
            end
            S_WSTB: begin
                if (cnt_q == STB_LAST) begin
                    we_d       = 1'b0;
                    cnt_d      = '0;
                    tx_data_d  = RSP_OK;
                    tx_valid_d = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RSTB: begin
                if (cnt_q == STB_LAST) begin
                    re_d  = 1'b0;
                    cnt_d = '0;
                    if (READ_WAIT == 0) begin
                        tx_data_d  = data_read;
                        tx_valid_d = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_RWAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RWAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d      = '0;
                    tx_data_d  = data_read;
                    tx_valid_d = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                // Valid/ready: tx_data is held while tx_valid is high; a beat moves
                // on any cycle with tx_valid && tx_ready, and valid never drops early.
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign re          = re_q;
    assign we          = we_q;
    assign addr        = addr_q;
    assign data_write  = wdata_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;

endmodule
